// File: rtl/bvult_bvmul_witness_checker.sv
`default_nettype none
// ============================================================================
// Module   : bvult_bvmul_witness_checker
// Function : Serially computes prod = x*s mod 2^W, checks whether x is a valid
//            witness for x*s <u t, and counts checked and bad witnesses.
// Revision : 1.0
// ============================================================================
module bvult_bvmul_witness_checker #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  prod,
  output logic          holds,
  output logic          ic,
  output logic          witness_ok,
  output logic [CW-1:0] n_checked,
  output logic [CW-1:0] n_bad
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [W-1:0]        s_q, t_q, x_q;
  logic [W-1:0]        acc_q;
  logic [W-1:0]        acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_ready_q, out_valid_q;
  logic [W-1:0]        prod_q;
  logic                holds_q, ic_q, witness_ok_q;
  logic [CW-1:0]       n_checked_q, n_bad_q;
  logic                holds_d, ic_d;
  logic                last_bit;

  // One partial product per cycle; the shift naturally truncates to W bits.
  always_comb begin
    acc_d = acc_q;
    if (x_q[cnt_q]) begin
      acc_d = acc_q + (s_q << cnt_q);
    end
  end

  assign last_bit = (cnt_q == CNT_W'(W - 1));
  assign holds_d  = (acc_d < t_q);
  assign ic_d     = (t_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      s_q          <= '0;
      t_q          <= '0;
      x_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      prod_q       <= '0;
      holds_q      <= 1'b0;
      ic_q         <= 1'b0;
      witness_ok_q <= 1'b0;
      n_checked_q  <= '0;
      n_bad_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_q        <= s;
            t_q        <= t;
            x_q        <= x;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            prod_q       <= acc_d;
            holds_q      <= holds_d;
            ic_q         <= ic_d;
            witness_ok_q <= (holds_d == ic_d);
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
            if (n_checked_q != '1) begin
              n_checked_q <= n_checked_q + CW'(1);
            end
            if (!witness_ok_q && (n_bad_q != '1)) begin
              n_bad_q <= n_bad_q + CW'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign prod       = prod_q;
  assign holds      = holds_q;
  assign ic         = ic_q;
  assign witness_ok = witness_ok_q;
  assign n_checked  = n_checked_q;
  assign n_bad      = n_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_bvult_bvmul_witness_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bvult_bvmul_witness_checker
// Function : Directed and random checks of the witness checker against an
//            arithmetic reference model; a CW=2 copy runs in lockstep.
// Revision : 1.0
// ============================================================================
module tb_bvult_bvmul_witness_checker;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] s, t, x;

  logic         in_ready, out_valid, holds, ic, witness_ok;
  logic [W-1:0] prod;
  logic [15:0]  n_checked, n_bad;

  logic         in_ready2, out_valid2, holds2, ic2, witness_ok2;
  logic [W-1:0] prod2;
  logic [1:0]   n_checked2, n_bad2;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_checked = 0;
  int exp_bad     = 0;

  always #5 clk = ~clk;

  bvult_bvmul_witness_checker #(.W(W), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .holds(holds), .ic(ic), .witness_ok(witness_ok),
    .n_checked(n_checked), .n_bad(n_bad)
  );

  bvult_bvmul_witness_checker #(.W(W), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .s(s), .t(t), .x(x), .out_valid(out_valid2), .out_ready(out_ready),
    .prod(prod2), .holds(holds2), .ic(ic2), .witness_ok(witness_ok2),
    .n_checked(n_checked2), .n_bad(n_bad2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, ".n_checked"},  32'(n_checked),  32'(sat(exp_checked, 65535)));
    chk({tag, ".n_bad"},      32'(n_bad),      32'(sat(exp_bad, 65535)));
    chk({tag, ".n_checked2"}, 32'(n_checked2), 32'(sat(exp_checked, 3)));
    chk({tag, ".n_bad2"},     32'(n_bad2),     32'(sat(exp_bad, 3)));
  endtask

  // Full transaction: accept, wait for the result (optionally holding off the
  // consumer while scrambling the inputs), compare with the model, hand off.
  task automatic run_req(input string tag, input int sv, input int tv, input int xv,
                         input int stall);
    int n;
    int e_prod;
    bit e_holds, e_ic, e_ok;
    e_prod  = (sv * xv) % (1 << W);
    e_holds = (e_prod < tv);
    e_ic    = (tv != 0);
    e_ok    = (e_holds == e_ic);

    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    s = W'(sv); t = W'(tv); x = W'(xv); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      s = W'($urandom); t = W'($urandom); x = W'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom) & ~out_valid;
      @(posedge clk); #1;
      n++;
      out_ready = 1'b0;
    end
    chk({tag, ".latency"}, 32'(n), 32'(W));
    for (int i = 0; i < stall; i++) begin
      s = W'($urandom); t = W'($urandom); x = W'($urandom);
      in_valid = ~in_valid;
      @(posedge clk); #1;
      chk({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".stall_prod"},     32'(prod),     32'(e_prod));
      chk({tag, ".stall_holds"},    32'(holds),    32'(e_holds));
    end
    in_valid = 1'b0;
    chk({tag, ".out_valid"},  32'(out_valid),  32'd1);
    chk({tag, ".prod"},       32'(prod),       32'(e_prod));
    chk({tag, ".holds"},      32'(holds),      32'(e_holds));
    chk({tag, ".ic"},         32'(ic),         32'(e_ic));
    chk({tag, ".witness_ok"}, 32'(witness_ok), 32'(e_ok));
    chk({tag, ".prod2"},      32'(prod2),      32'(e_prod));
    chk_counters({tag, ".pre"});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_checked++;
    if (!e_ok) exp_bad++;
    chk({tag, ".done_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".done_in_ready"},  32'(in_ready),  32'd1);
    chk_counters({tag, ".post"});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
    chk({tag, ".out_valid"},  32'(out_valid),  32'd0);
    chk({tag, ".prod"},       32'(prod),       32'd0);
    chk({tag, ".holds"},      32'(holds),      32'd0);
    chk({tag, ".ic"},         32'(ic),         32'd0);
    chk({tag, ".witness_ok"}, 32'(witness_ok), 32'd0);
    exp_checked = 0;
    exp_bad     = 0;
    chk_counters(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s = '0; t = '0; x = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");

    run_req("d035", 6, 3, 3, 0);
    run_req("d036", 3, 2, 5, 0);
    run_req("d037", 3, 0, 5, 0);
    run_req("d038", 6, 3, 3, 5);

    // Reset two edges after accepting; the request must vanish uncounted.
    s = 4'd7; t = 4'd9; x = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_reset_state("midrst");
    run_req("d039", 7, 9, 7, 0);

    for (int i = 0; i < 40; i++) begin
      run_req("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("rst2");
    for (int i = 0; i < 5; i++) begin
      run_req("d040", 3, 2, 5, 0);
    end
    chk("sat.n_bad2",     32'(n_bad2),     32'd3);
    chk("sat.n_checked2", 32'(n_checked2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
